// File: rtl/gain_oot_pkg.sv
// Shared constants for the gain_oot user-logic core: CtrlPort register
// offsets and the unity-gain helper used to derive the reset gain.
package gain_oot_pkg;

    localparam logic [19:0] REG_GAIN          = 20'h00000;
    localparam logic [19:0] REG_SAT_COUNT     = 20'h00004;
    localparam int          GAIN_FRAC_DEFAULT = 8;
    localparam logic [31:0] GAIN_UNITY        = 32'd1 << GAIN_FRAC_DEFAULT;

    function automatic logic [31:0] unity_gain(input int frac);
        return 32'd1 << frac;
    endfunction

    // Word-aligned decode: the byte-lane bits addr[1:0] never take part.
    function automatic logic reg_hit(input logic [19:0] addr, input logic [19:0] offset);
        return addr[19:2] == offset[19:2];
    endfunction

endpackage

// File: rtl/gain_oot_sat_mult.sv
// One sc16 component: signed-by-unsigned multiply (stage-1 side) and
// floor shift plus saturation with a clip flag (stage-2 side), combinational only.
module gain_oot_sat_mult #(
    parameter  int GAIN_W    = 16,
    parameter  int GAIN_FRAC = 8,
    localparam int PROD_W    = 16 + GAIN_W + 1
) (
    input  logic [15:0]       i_sample,
    input  logic [GAIN_W-1:0] i_gain,
    output logic [PROD_W-1:0] o_product,
    input  logic [PROD_W-1:0] i_product,
    output logic [15:0]       o_result,
    output logic              o_sat
);

    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(32767);
    localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-32768);

    logic signed [PROD_W-1:0] w_sample_ext;
    logic signed [PROD_W-1:0] w_gain_ext;
    logic signed [PROD_W-1:0] w_shifted;

    // The gain is unsigned, so it is zero-extended before the signed multiply.
    assign w_sample_ext = PROD_W'($signed(i_sample));
    assign w_gain_ext   = PROD_W'({1'b0, i_gain});
    assign o_product    = w_sample_ext * w_gain_ext;

    assign w_shifted = $signed(i_product) >>> GAIN_FRAC;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_result = w_shifted[15:0];
        o_sat    = 1'b0;
        if (w_shifted > SAT_MAX) begin
            o_result = 16'h7FFF;
            o_sat    = 1'b1;
        end else if (w_shifted < SAT_MIN) begin
            o_result = 16'h8000;
            o_sat    = 1'b1;
        end
    end

endmodule

// File: rtl/gain_oot.sv
// gain_oot_core: sc16 fixed-point gain with saturation behind noc_shell_gain_oot,
// with a CtrlPort register file, packet-aligned gain updates and context passthrough.
module gain_oot_core
    import gain_oot_pkg::*;
#(
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 8,
    parameter int SAT_CNT_W = 32
) (
    input  logic        axis_data_clk,
    input  logic        axis_data_rst,
    input  logic        s_ctrlport_req_wr,
    input  logic        s_ctrlport_req_rd,
    input  logic [19:0] s_ctrlport_req_addr,
    input  logic [31:0] s_ctrlport_req_data,
    output logic        s_ctrlport_resp_ack,
    output logic [31:0] s_ctrlport_resp_data,
    input  logic [31:0] s_in_payload_tdata,
    input  logic        s_in_payload_tkeep,
    input  logic        s_in_payload_tlast,
    input  logic        s_in_payload_tvalid,
    output logic        s_in_payload_tready,
    input  logic [63:0] s_in_context_tdata,
    input  logic [3:0]  s_in_context_tuser,
    input  logic        s_in_context_tlast,
    input  logic        s_in_context_tvalid,
    output logic        s_in_context_tready,
    output logic [31:0] m_out_payload_tdata,
    output logic        m_out_payload_tkeep,
    output logic        m_out_payload_tlast,
    output logic        m_out_payload_tvalid,
    input  logic        m_out_payload_tready,
    output logic [63:0] m_out_context_tdata,
    output logic [3:0]  m_out_context_tuser,
    output logic        m_out_context_tlast,
    output logic        m_out_context_tvalid,
    input  logic        m_out_context_tready
);

    localparam int                PROD_W     = 16 + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] RESET_GAIN = GAIN_W'(unity_gain(GAIN_FRAC));

    logic [GAIN_W-1:0]    r_gain_reg;
    logic [GAIN_W-1:0]    r_gain_active;
    logic                 r_in_pkt;
    logic [SAT_CNT_W-1:0] r_sat_cnt;
    logic                 r_ack;
    logic [31:0]          r_resp_data;

    logic                 r_s1_valid;
    logic [PROD_W-1:0]    r_s1_prod_i;
    logic [PROD_W-1:0]    r_s1_prod_q;
    logic                 r_s1_last;
    logic                 r_s1_keep;

    logic                 r_s2_valid;
    logic [31:0]          r_s2_data;
    logic                 r_s2_last;
    logic                 r_s2_keep;

    logic                 w_s1_adv;
    logic                 w_s2_adv;
    logic                 w_in_fire;
    logic                 w_s2_load;
    logic                 w_sat_inc;
    logic                 w_wr_gain;
    logic                 w_wr_sat;
    logic [GAIN_W-1:0]    w_gain_eff;
    logic [PROD_W-1:0]    w_prod_i;
    logic [PROD_W-1:0]    w_prod_q;
    logic [15:0]          w_res_i;
    logic [15:0]          w_res_q;
    logic                 w_sat_i;
    logic                 w_sat_q;
    logic [31:0]          w_rd_data;
    logic                 w_unused_ctrl;

    assign w_unused_ctrl = ^{s_ctrlport_req_addr[1:0], s_ctrlport_req_data};

    // Context is ordered against payload by the shell, so it simply passes through.
    assign m_out_context_tdata  = s_in_context_tdata;
    assign m_out_context_tuser  = s_in_context_tuser;
    assign m_out_context_tlast  = s_in_context_tlast;
    assign m_out_context_tvalid = s_in_context_tvalid;
    assign s_in_context_tready  = m_out_context_tready;

    assign w_s2_adv  = !r_s2_valid || m_out_payload_tready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    // No sample may be accepted while the core is held in reset.
    assign s_in_payload_tready = w_s1_adv && !axis_data_rst;
    assign w_in_fire = s_in_payload_tvalid && s_in_payload_tready;
    assign w_s2_load = w_s2_adv && r_s1_valid;

    // The first sample of a packet already uses the freshly latched gain.
    assign w_gain_eff = r_in_pkt ? r_gain_active : r_gain_reg;

    gain_oot_sat_mult #(.GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)) u_mult_i (
        .i_sample  (s_in_payload_tdata[31:16]),
        .i_gain    (w_gain_eff),
        .o_product (w_prod_i),
        .i_product (r_s1_prod_i),
        .o_result  (w_res_i),
        .o_sat     (w_sat_i)
    );

    gain_oot_sat_mult #(.GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)) u_mult_q (
        .i_sample  (s_in_payload_tdata[15:0]),
        .i_gain    (w_gain_eff),
        .o_product (w_prod_q),
        .i_product (r_s1_prod_q),
        .o_result  (w_res_q),
        .o_sat     (w_sat_q)
    );

    assign w_sat_inc = w_s2_load && (w_sat_i || w_sat_q);
    assign w_wr_gain = s_ctrlport_req_wr && reg_hit(s_ctrlport_req_addr, REG_GAIN);
    assign w_wr_sat  = s_ctrlport_req_wr && reg_hit(s_ctrlport_req_addr, REG_SAT_COUNT);

    always_comb begin
        w_rd_data = '0;
        if (reg_hit(s_ctrlport_req_addr, REG_GAIN)) begin
            w_rd_data = 32'(r_gain_reg);
        end else if (reg_hit(s_ctrlport_req_addr, REG_SAT_COUNT)) begin
            w_rd_data = 32'(r_sat_cnt);
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
        if (axis_data_rst) begin
            r_ack       <= 1'b0;
            r_resp_data <= '0;
            r_gain_reg  <= RESET_GAIN;
        end else begin
            r_ack       <= s_ctrlport_req_wr || s_ctrlport_req_rd;
            r_resp_data <= s_ctrlport_req_rd ? w_rd_data : 32'd0;
            if (w_wr_gain) begin
                r_gain_reg <= s_ctrlport_req_data[GAIN_W-1:0];
            end
        end
    end

    // A clear-on-write beats a simultaneous increment; the count sticks at all-ones.
    always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
        if (axis_data_rst) begin
            r_sat_cnt <= '0;
        end else if (w_wr_sat) begin
            r_sat_cnt <= '0;
        end else if (w_sat_inc && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + SAT_CNT_W'(1);
        end
    end

    always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
        if (axis_data_rst) begin
            r_gain_active <= RESET_GAIN;
            r_in_pkt      <= 1'b0;
        end else if (w_in_fire) begin
            if (!r_in_pkt) begin
                r_gain_active <= r_gain_reg;
            end
            r_in_pkt <= !s_in_payload_tlast;
        end
    end

    always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
        if (axis_data_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_prod_i <= '0;
            r_s1_prod_q <= '0;
            r_s1_last   <= 1'b0;
            r_s1_keep   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_data   <= '0;
            r_s2_last   <= 1'b0;
            r_s2_keep   <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= s_in_payload_tvalid;
                if (s_in_payload_tvalid) begin
                    r_s1_prod_i <= w_prod_i;
                    r_s1_prod_q <= w_prod_q;
                    r_s1_last   <= s_in_payload_tlast;
                    r_s1_keep   <= s_in_payload_tkeep;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_load) begin
                r_s2_data <= {w_res_i, w_res_q};
                r_s2_last <= r_s1_last;
                r_s2_keep <= r_s1_keep;
            end
        end
    end

    assign s_ctrlport_resp_ack  = r_ack;
    assign s_ctrlport_resp_data = r_resp_data;
    assign m_out_payload_tvalid = r_s2_valid;
    assign m_out_payload_tdata  = r_s2_data;
    assign m_out_payload_tlast  = r_s2_last;
    assign m_out_payload_tkeep  = r_s2_keep;

endmodule

// File: tb/tb_gain_oot_core.sv
// Self-checking bench for gain_oot_core: directed vector table plus hand-written
// packet, gain-timing, backpressure, register-map and reset sequences.
`timescale 1ns/1ps
module tb_gain_oot_core;
    import gain_oot_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_ctrlport_req_wr = 1'b0;
    logic        s_ctrlport_req_rd = 1'b0;
    logic [19:0] s_ctrlport_req_addr = '0;
    logic [31:0] s_ctrlport_req_data = '0;
    logic        s_ctrlport_resp_ack;
    logic [31:0] s_ctrlport_resp_data;
    logic [31:0] s_in_payload_tdata = '0;
    logic        s_in_payload_tkeep = 1'b0;
    logic        s_in_payload_tlast = 1'b0;
    logic        s_in_payload_tvalid = 1'b0;
    logic        s_in_payload_tready;
    logic [63:0] s_in_context_tdata = '0;
    logic [3:0]  s_in_context_tuser = '0;
    logic        s_in_context_tlast = 1'b0;
    logic        s_in_context_tvalid = 1'b0;
    logic        s_in_context_tready;
    logic [31:0] m_out_payload_tdata;
    logic        m_out_payload_tkeep;
    logic        m_out_payload_tlast;
    logic        m_out_payload_tvalid;
    logic        m_out_payload_tready;
    logic [63:0] m_out_context_tdata;
    logic [3:0]  m_out_context_tuser;
    logic        m_out_context_tlast;
    logic        m_out_context_tvalid;
    logic        m_out_context_tready = 1'b1;

    logic rdy_val   = 1'b1;
    logic rand_mode = 1'b0;
    logic rand_bit  = 1'b0;
    assign m_out_payload_tready = rand_mode ? rand_bit : rdy_val;

    always #5 clk = ~clk;

    gain_oot_core #(.GAIN_W(16), .GAIN_FRAC(8), .SAT_CNT_W(32)) dut (
        .axis_data_clk        (clk),
        .axis_data_rst        (rst),
        .s_ctrlport_req_wr    (s_ctrlport_req_wr),
        .s_ctrlport_req_rd    (s_ctrlport_req_rd),
        .s_ctrlport_req_addr  (s_ctrlport_req_addr),
        .s_ctrlport_req_data  (s_ctrlport_req_data),
        .s_ctrlport_resp_ack  (s_ctrlport_resp_ack),
        .s_ctrlport_resp_data (s_ctrlport_resp_data),
        .s_in_payload_tdata   (s_in_payload_tdata),
        .s_in_payload_tkeep   (s_in_payload_tkeep),
        .s_in_payload_tlast   (s_in_payload_tlast),
        .s_in_payload_tvalid  (s_in_payload_tvalid),
        .s_in_payload_tready  (s_in_payload_tready),
        .s_in_context_tdata   (s_in_context_tdata),
        .s_in_context_tuser   (s_in_context_tuser),
        .s_in_context_tlast   (s_in_context_tlast),
        .s_in_context_tvalid  (s_in_context_tvalid),
        .s_in_context_tready  (s_in_context_tready),
        .m_out_payload_tdata  (m_out_payload_tdata),
        .m_out_payload_tkeep  (m_out_payload_tkeep),
        .m_out_payload_tlast  (m_out_payload_tlast),
        .m_out_payload_tvalid (m_out_payload_tvalid),
        .m_out_payload_tready (m_out_payload_tready),
        .m_out_context_tdata  (m_out_context_tdata),
        .m_out_context_tuser  (m_out_context_tuser),
        .m_out_context_tlast  (m_out_context_tlast),
        .m_out_context_tvalid (m_out_context_tvalid),
        .m_out_context_tready (m_out_context_tready)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int hs_cyc   = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } beat_t;
    beat_t out_q[$];

    typedef struct {
        logic [15:0] gain;
        logic [31:0] din;
        logic [31:0] dout;
        logic        sat;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    // Output monitor: records handshakes and checks hold-under-stall.
    logic        mon_en     = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_valid", 64'(m_out_payload_tvalid), 64'd1);
                check("stall_data", {m_out_payload_tlast, m_out_payload_tdata}, {prev_last, prev_data});
            end
            if (m_out_payload_tvalid && m_out_payload_tready)
                out_q.push_back('{m_out_payload_tdata, m_out_payload_tlast, cyc});
            prev_stall = m_out_payload_tvalid && !m_out_payload_tready;
            prev_data  = m_out_payload_tdata;
            prev_last  = m_out_payload_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic ctrl_access(input logic wr, input logic rd, input logic [19:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata);
        s_ctrlport_req_wr   = wr;
        s_ctrlport_req_rd   = rd;
        s_ctrlport_req_addr = addr;
        s_ctrlport_req_data = wdata;
        @(posedge clk); #1;
        s_ctrlport_req_wr = 1'b0;
        s_ctrlport_req_rd = 1'b0;
        check("ack_one_cycle", 64'(s_ctrlport_resp_ack), 64'd1);
        rdata = s_ctrlport_resp_data;
        @(posedge clk); #1;
        check("ack_idle", {s_ctrlport_resp_ack, s_ctrlport_resp_data}, 64'd0);
    endtask

    task automatic ctrl_write(input logic [19:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        ctrl_access(1'b1, 1'b0, addr, wdata, dummy);
    endtask

    task automatic ctrl_read(input logic [19:0] addr, output logic [31:0] rdata);
        ctrl_access(1'b0, 1'b1, addr, 32'd0, rdata);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        logic hs;
        hs = 1'b0;
        s_in_payload_tdata  = d;
        s_in_payload_tlast  = last;
        s_in_payload_tkeep  = 1'b1;
        s_in_payload_tvalid = 1'b1;
        for (int t = 0; t < 2000 && !hs; t++) begin
            @(negedge clk);
            hs = s_in_payload_tready;
            if (hs) hs_cyc = cyc;
            @(posedge clk); #1;
        end
        if (!hs) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle_in();
        s_in_payload_tvalid = 1'b0;
        s_in_payload_tlast  = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (out_q.size() < n && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("out_count", 64'(out_q.size()), 64'(n));
    endtask

    task automatic check_out(input string name, input int idx, input logic [31:0] d, input logic last);
        if (idx >= out_q.size()) check({name, "_missing"}, 64'd0, 64'd1);
        else check(name, {out_q[idx].last, out_q[idx].data}, {last, d});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int first_hs;
        int exp_sat;

        vecs[0] = '{16'h0080, 32'h0003FFFD, 32'h0001FFFE, 1'b0};
        vecs[1] = '{16'h0080, 32'hFFFF0001, 32'hFFFF0000, 1'b0};
        vecs[2] = '{16'hFFFF, 32'h7FFF0000, 32'h7FFF0000, 1'b1};
        vecs[3] = '{16'hFFFF, 32'h80000001, 32'h800000FF, 1'b1};
        vecs[4] = '{16'h0000, 32'h7FFF8000, 32'h00000000, 1'b0};
        vecs[5] = '{16'h0100, 32'h80007FFF, 32'h80007FFF, 1'b0};
        vecs[6] = '{16'h0180, 32'h0002FFFE, 32'h0003FFFD, 1'b0};
        vecs[7] = '{16'h0180, 32'h55560000, 32'h7FFF0000, 1'b1};
        vecs[8] = '{16'h0200, 32'h3FFFC000, 32'h7FFE8000, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(m_out_payload_tvalid), 64'd0);
        check("rst_out_data", {m_out_payload_tlast, m_out_payload_tkeep, m_out_payload_tdata}, 64'd0);
        check("rst_in_ready", 64'(s_in_payload_tready), 64'd0);
        check("rst_ctrl", {s_ctrlport_resp_ack, s_ctrlport_resp_data}, 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        ctrl_read(REG_GAIN, rd);
        check("reset_gain", 64'(rd), 64'h100);
        ctrl_read(REG_SAT_COUNT, rd);
        check("reset_sat", 64'(rd), 64'd0);

        // Unity gain passthrough with latency
        out_q.delete();
        send_beat(32'h1234EDCC, 1'b0);
        first_hs = hs_cyc;
        send_beat(32'h7FFF8000, 1'b1);
        idle_in();
        wait_out(2);
        check_out("unity_0", 0, 32'h1234EDCC, 1'b0);
        check_out("unity_1", 1, 32'h7FFF8000, 1'b1);
        if (out_q.size() > 0) check("latency", 64'(out_q[0].cyc - first_hs), 64'd2);
        ctrl_read(REG_SAT_COUNT, rd);
        check("unity_sat", 64'(rd), 64'd0);

        // Gain 2.0 with saturation
        ctrl_write(REG_GAIN, 32'h0200);
        out_q.delete();
        send_beat(32'h3000D000, 1'b0);
        send_beat(32'h5000A000, 1'b1);
        idle_in();
        wait_out(2);
        check_out("gain2_0", 0, 32'h6000A000, 1'b0);
        check_out("gain2_1", 1, 32'h7FFF8000, 1'b1);
        ctrl_read(REG_SAT_COUNT, rd);
        check("gain2_sat", 64'(rd), 64'd1);
        ctrl_write(REG_SAT_COUNT, 32'hDEAD_BEEF);
        ctrl_read(REG_SAT_COUNT, rd);
        check("sat_clear", 64'(rd), 64'd0);

        // Mid-packet gain write applies only to the next packet
        ctrl_write(REG_GAIN, 32'h0100);
        out_q.delete();
        for (int i = 0; i < 2; i++) send_beat(32'h01000100, 1'b0);
        idle_in();
        ctrl_write(REG_GAIN, 32'h0080);
        for (int i = 2; i < 8; i++) send_beat(32'h01000100, i == 7);
        idle_in();
        wait_out(8);
        for (int i = 0; i < 8; i++) check_out("midpkt_old_gain", i, 32'h01000100, i == 7);
        out_q.delete();
        send_beat(32'h01000100, 1'b0);
        send_beat(32'h01000100, 1'b1);
        idle_in();
        wait_out(2);
        check_out("next_pkt_0", 0, 32'h00800080, 1'b0);
        check_out("next_pkt_1", 1, 32'h00800080, 1'b1);

        // GAIN upper bits read back as zero
        ctrl_write(REG_GAIN, 32'hFFFF_FFFF);
        ctrl_read(REG_GAIN, rd);
        check("gain_width", 64'(rd), 64'h0000FFFF);

        // Vector table: one single-sample packet per record
        ctrl_write(REG_SAT_COUNT, 32'd0);
        exp_sat = 0;
        for (int v = 0; v < 9; v++) begin
            ctrl_write(REG_GAIN, 32'(vecs[v].gain));
            out_q.delete();
            send_beat(vecs[v].din, 1'b1);
            idle_in();
            wait_out(1);
            check_out($sformatf("vec%0d", v), 0, vecs[v].dout, 1'b1);
            if (vecs[v].sat) exp_sat++;
        end
        ctrl_read(REG_SAT_COUNT, rd);
        check("vec_sat_count", 64'(rd), 64'(exp_sat));

        // Unmapped addresses and ignored byte-lane bits
        ctrl_write(REG_GAIN, 32'h0123);
        ctrl_read(20'h00010, rd);
        check("unmapped_rd", 64'(rd), 64'd0);
        ctrl_write(20'h00010, 32'hFFFF_FFFF);
        ctrl_read(REG_GAIN, rd);
        check("unmapped_wr", 64'(rd), 64'h0123);
        ctrl_read(20'h00003, rd);
        check("addr_lsb_ignored", 64'(rd), 64'h0123);

        // Ramp under random backpressure
        ctrl_write(REG_GAIN, 32'h0100);
        out_q.delete();
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) send_beat({16'(i), ~16'(i)}, (i % 100) == 99);
        idle_in();
        wait_out(1000);
        rand_mode = 1'b0;
        for (int i = 0; i < 1000; i++) check_out("ramp", i, {16'(i), ~16'(i)}, (i % 100) == 99);

        // Full throughput with ready held high
        rdy_val = 1'b1;
        out_q.delete();
        for (int i = 0; i < 32; i++) send_beat(32'hA5000000 | 32'(i), i == 31);
        idle_in();
        wait_out(32);
        for (int i = 1; i < 32; i++) begin
            if (i < out_q.size()) check("tput_gap", 64'(out_q[i].cyc - out_q[i-1].cyc), 64'd1);
            check_out("tput_data", i, 32'hA5000000 | 32'(i), i == 31);
        end

        // Context passthrough
        s_in_context_tdata   = 64'h0123_4567_89AB_CDEF;
        s_in_context_tuser   = 4'hA;
        s_in_context_tlast   = 1'b1;
        s_in_context_tvalid  = 1'b1;
        m_out_context_tready = 1'b1;
        #1;
        check("ctx_data", m_out_context_tdata, 64'h0123_4567_89AB_CDEF);
        check("ctx_side", {m_out_context_tuser, m_out_context_tlast, m_out_context_tvalid}, {4'hA, 1'b1, 1'b1});
        check("ctx_ready_hi", 64'(s_in_context_tready), 64'd1);
        m_out_context_tready = 1'b0;
        #1;
        check("ctx_ready_lo", 64'(s_in_context_tready), 64'd0);
        s_in_context_tdata   = '0;
        s_in_context_tuser   = '0;
        s_in_context_tlast   = 1'b0;
        s_in_context_tvalid  = 1'b0;
        m_out_context_tready = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset mid-packet with the output stalled
        ctrl_write(REG_GAIN, 32'h0080);
        rdy_val = 1'b0;
        out_q.delete();
        s_in_payload_tdata  = 32'h11112222;
        s_in_payload_tlast  = 1'b0;
        s_in_payload_tkeep  = 1'b1;
        s_in_payload_tvalid = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        check("pre_rst_stalled", {m_out_payload_tvalid, s_in_payload_tready}, 64'b10);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(m_out_payload_tvalid), 64'd0);
        check("async_rst_data", {m_out_payload_tlast, m_out_payload_tkeep, m_out_payload_tdata}, 64'd0);
        check("async_rst_ready", 64'(s_in_payload_tready), 64'd0);
        check("async_rst_ctrl", {s_ctrlport_resp_ack, s_ctrlport_resp_data}, 64'd0);
        idle_in();
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_val = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        ctrl_read(REG_GAIN, rd);
        check("post_rst_gain", 64'(rd), 64'h100);
        out_q.delete();
        send_beat(32'h1234EDCC, 1'b0);
        send_beat(32'h7FFF8000, 1'b1);
        idle_in();
        wait_out(2);
        check_out("post_rst_0", 0, 32'h1234EDCC, 1'b0);
        check_out("post_rst_1", 1, 32'h7FFF8000, 1'b1);
        ctrl_write(REG_GAIN, 32'h0200);
        out_q.delete();
        send_beat(32'h10002000, 1'b1);
        idle_in();
        wait_out(1);
        check_out("post_rst_newpkt", 0, 32'h20004000, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
